dual_sram_ctrl: RTL and testbench

Request-side controller that drives both ports of the team's 2-port synchronous SRAM (shared chip select; per-port read-enable, address, write data and read data).
- Exposes two independent valid/ready request channels (A, B) and two response channels to upstream logic.
- Converts each request into correctly-timed SRAM port signals and returns read data.
- The SRAM treats chip select with read-enable low as a write, so this block must never leave an idle port in write mode while chip select is high.

---
 rtl/dual_sram_ctrl_port.sv | 42 ++++
 rtl/dual_sram_ctrl.sv | 83 ++++++++
 tb/tb_dual_sram_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dual_sram_ctrl_port.sv
// One SRAM port's command registers and read-response tracking.
// Any cycle without an accepted request issues a dummy read, so the port never writes by accident.
module dual_sram_ctrl_port #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  accept,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  mem_read_ena,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  rsp_valid
);

    logic pending_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_ena <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            pending_reg  <= 1'b0;
            rsp_valid    <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr     <= req_addr;
                mem_wdata    <= req_wdata;
                mem_read_ena <= !req_we;
            end else begin
                mem_read_ena <= 1'b1;
            end
            // The SRAM registers its output one edge after the command lands.
            pending_reg <= accept && !req_we;
            rsp_valid   <= pending_reg;
        end
    end

endmodule

// File: rtl/dual_sram_ctrl.sv
// Two-channel request controller for a 2-port synchronous SRAM with shared chip select.
// Port A wins same-address write collisions; port B stalls for that cycle.
module dual_sram_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_a,
    output logic                  req_ready_a,
    input  logic                  req_we_a,
    input  logic [ADDR_WIDTH-1:0] req_addr_a,
    input  logic [WIDTH-1:0]      req_wdata_a,
    output logic                  rsp_valid_a,
    output logic [WIDTH-1:0]      rsp_data_a,
    input  logic                  req_valid_b,
    output logic                  req_ready_b,
    input  logic                  req_we_b,
    input  logic [ADDR_WIDTH-1:0] req_addr_b,
    input  logic [WIDTH-1:0]      req_wdata_b,
    output logic                  rsp_valid_b,
    output logic [WIDTH-1:0]      rsp_data_b,
    output logic                  mem_chip_sel,
    output logic                  mem_read_ena_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic [WIDTH-1:0]      mem_wdata_a,
    input  logic [WIDTH-1:0]      mem_dout_a,
    output logic                  mem_read_ena_b,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    output logic [WIDTH-1:0]      mem_wdata_b,
    input  logic [WIDTH-1:0]      mem_dout_b
);

    logic ww_conflict;
    logic accept_a;
    logic accept_b;

    assign ww_conflict = req_valid_a && req_we_a && req_valid_b && req_we_b &&
                         (req_addr_a == req_addr_b);
    assign req_ready_a = !reset;
    assign req_ready_b = !reset && !ww_conflict;
    assign accept_a    = req_valid_a && req_ready_a;
    assign accept_b    = req_valid_b && req_ready_b;

    assign rsp_data_a = mem_dout_a;
    assign rsp_data_b = mem_dout_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_chip_sel <= 1'b0;
        end else begin
            mem_chip_sel <= accept_a || accept_b;
        end
    end

    dual_sram_ctrl_port #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_port_a (
        .clk          (clk),
        .reset        (reset),
        .accept       (accept_a),
        .req_we       (req_we_a),
        .req_addr     (req_addr_a),
        .req_wdata    (req_wdata_a),
        .mem_read_ena (mem_read_ena_a),
        .mem_addr     (mem_addr_a),
        .mem_wdata    (mem_wdata_a),
        .rsp_valid    (rsp_valid_a)
    );

    dual_sram_ctrl_port #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_port_b (
        .clk          (clk),
        .reset        (reset),
        .accept       (accept_b),
        .req_we       (req_we_b),
        .req_addr     (req_addr_b),
        .req_wdata    (req_wdata_b),
        .mem_read_ena (mem_read_ena_b),
        .mem_addr     (mem_addr_b),
        .mem_wdata    (mem_wdata_b),
        .rsp_valid    (rsp_valid_b)
    );

endmodule

// File: tb/tb_dual_sram_ctrl.sv
// Directed bench for dual_sram_ctrl with a behavioural 2-port SRAM attached.
module tb_dual_sram_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk;
    logic             reset;
    logic             req_valid_a, req_ready_a, req_we_a;
    logic [AW-1:0]    req_addr_a;
    logic [WIDTH-1:0] req_wdata_a;
    logic             rsp_valid_a;
    logic [WIDTH-1:0] rsp_data_a;
    logic             req_valid_b, req_ready_b, req_we_b;
    logic [AW-1:0]    req_addr_b;
    logic [WIDTH-1:0] req_wdata_b;
    logic             rsp_valid_b;
    logic [WIDTH-1:0] rsp_data_b;
    logic             mem_chip_sel;
    logic             mem_read_ena_a, mem_read_ena_b;
    logic [AW-1:0]    mem_addr_a, mem_addr_b;
    logic [WIDTH-1:0] mem_wdata_a, mem_wdata_b;
    logic [WIDTH-1:0] mem_dout_a, mem_dout_b;

    logic [WIDTH-1:0] sram [DEPTH];

    int checks   = 0;
    int failures = 0;

    dual_sram_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_a    (req_valid_a),
        .req_ready_a    (req_ready_a),
        .req_we_a       (req_we_a),
        .req_addr_a     (req_addr_a),
        .req_wdata_a    (req_wdata_a),
        .rsp_valid_a    (rsp_valid_a),
        .rsp_data_a     (rsp_data_a),
        .req_valid_b    (req_valid_b),
        .req_ready_b    (req_ready_b),
        .req_we_b       (req_we_b),
        .req_addr_b     (req_addr_b),
        .req_wdata_b    (req_wdata_b),
        .rsp_valid_b    (rsp_valid_b),
        .rsp_data_b     (rsp_data_b),
        .mem_chip_sel   (mem_chip_sel),
        .mem_read_ena_a (mem_read_ena_a),
        .mem_addr_a     (mem_addr_a),
        .mem_wdata_a    (mem_wdata_a),
        .mem_dout_a     (mem_dout_a),
        .mem_read_ena_b (mem_read_ena_b),
        .mem_addr_b     (mem_addr_b),
        .mem_wdata_b    (mem_wdata_b),
        .mem_dout_b     (mem_dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: chip select with read enable low is a write; reads return pre-write data.
    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = '0;
        mem_dout_a = '0;
        mem_dout_b = '0;
    end

    always @(posedge clk) begin
        if (mem_chip_sel) begin
            if (mem_read_ena_a) mem_dout_a <= sram[mem_addr_a];
            else                sram[mem_addr_a] <= mem_wdata_a;
            if (mem_read_ena_b) mem_dout_b <= sram[mem_addr_b];
            else                sram[mem_addr_b] <= mem_wdata_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle_a();
        req_valid_a = 1'b0; req_we_a = 1'b0; req_addr_a = '0; req_wdata_a = '0;
    endtask

    task automatic idle_b();
        req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_byte;

        reset = 1'b1;
        idle_a();
        idle_b();
        req_valid_a = 1'b1;

        // 1. Reset held two cycles with a request pending on A
        #1;
        chk("rst_ready_a_pre", req_ready_a, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_chip_sel", mem_chip_sel, 0);
            chk("rst_mem_ctl", {mem_read_ena_a, mem_read_ena_b, mem_addr_a, mem_addr_b,
                                mem_wdata_a, mem_wdata_b}, 0);
            chk("rst_rsp_valid", {rsp_valid_a, rsp_valid_b}, 0);
            chk("rst_ready", {req_ready_a, req_ready_b}, 0);
        end
        reset = 1'b0;
        idle_a();
        #1;
        chk("rel_ready_a", req_ready_a, 1);
        chk("rel_ready_b", req_ready_b, 1);

        // 2. A writes 0x5A to addr 3, then reads it back; B idle
        req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 3'd3; req_wdata_a = 8'h5A;
        tick();
        chk("t2_wr_read_ena_a", mem_read_ena_a, 0);
        chk("t2_wr_cmd_a", {mem_addr_a, mem_wdata_a}, {3'd3, 8'h5A});
        chk("t2_wr_chip_sel", mem_chip_sel, 1);
        chk("t2_wr_dummy_b", mem_read_ena_b, 1);
        req_we_a = 1'b0;
        tick();
        chk("t2_rd_read_ena_a", mem_read_ena_a, 1);
        chk("t2_rd_dummy_b", mem_read_ena_b, 1);
        chk("t2_rsp_early", rsp_valid_a, 0);
        idle_a();
        tick();
        chk("t2_rsp_valid", rsp_valid_a, 1);
        chk("t2_rsp_data", rsp_data_a, 8'h5A);
        chk("t2_rsp_b_quiet", rsp_valid_b, 0);
        tick();
        chk("t2_rsp_pulse_end", rsp_valid_a, 0);
        chk("t2_sram_addr3", sram[3], 8'h5A);

        // 3. Write-write collision on addr 5: A wins, B retries unchanged
        req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 3'd5; req_wdata_a = 8'h11;
        req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 3'd5; req_wdata_b = 8'h22;
        #1;
        chk("t3_ready_a", req_ready_a, 1);
        chk("t3_ready_b_stall", req_ready_b, 0);
        tick();
        chk("t3_a_write", {mem_read_ena_a, mem_wdata_a}, {1'b0, 8'h11});
        chk("t3_b_dummy", mem_read_ena_b, 1);
        idle_a();
        #1;
        chk("t3_ready_b_retry", req_ready_b, 1);
        tick();
        chk("t3_b_write", {mem_read_ena_b, mem_addr_b, mem_wdata_b}, {1'b0, 3'd5, 8'h22});
        req_we_b = 1'b0;
        tick();
        idle_b();
        tick();
        chk("t3_rsp_valid_b", rsp_valid_b, 1);
        chk("t3_rsp_data_b", rsp_data_b, 8'h22);
        tick();

        // 4. Same-cycle write on A and read on B to addr 2 returns old data
        req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 3'd2; req_wdata_a = 8'h77;
        req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 3'd2;
        #1;
        chk("t4_ready_b", req_ready_b, 1);
        tick();
        idle_a();
        tick();
        chk("t4_rsp_valid_old", rsp_valid_b, 1);
        chk("t4_rsp_data_old", rsp_data_b, 8'h00);
        idle_b();
        tick();
        chk("t4_rsp_valid_new", rsp_valid_b, 1);
        chk("t4_rsp_data_new", rsp_data_b, 8'h77);
        tick();
        chk("t4_rsp_end", rsp_valid_b, 0);

        // 5. Preload addrs 0..3 via A, then four back-to-back reads on B
        for (int i = 0; i < 4; i++) begin
            req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = AW'(i);
            req_wdata_a = WIDTH'(8'h10 * (i + 1));
            tick();
        end
        idle_a();
        for (int i = 0; i < 4; i++) begin
            req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = AW'(i);
            tick();
            if (i == 0) begin
                chk("t5_rsp_not_yet", rsp_valid_b, 0);
            end else begin
                exp_byte = WIDTH'(8'h10 * i);
                chk("t5_b2b_valid", rsp_valid_b, 1);
                chk("t5_b2b_data", rsp_data_b, exp_byte);
            end
        end
        idle_b();
        tick();
        chk("t5_last_valid", rsp_valid_b, 1);
        chk("t5_last_data", rsp_data_b, 8'h40);
        tick();
        chk("t5_done", rsp_valid_b, 0);

        // 6. Read accepted on A, then reset at the next edge drops it
        req_valid_a = 1'b1; req_we_a = 1'b0; req_addr_a = 3'd1;
        tick();
        idle_a();
        reset = 1'b1;
        tick();
        chk("t6_chip_sel", mem_chip_sel, 0);
        chk("t6_rsp_dropped", rsp_valid_a, 0);
        tick();
        chk("t6_rsp_dropped2", rsp_valid_a, 0);
        reset = 1'b0;
        tick();
        chk("t6_post_rsp", rsp_valid_a, 0);
        chk("t6_post_chip_sel", mem_chip_sel, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
